block_interleaver: RTL and testbench
====================================

// Module: block_interleaver
// PURPOSE
//   Parametrised ROWS x COLS block (de)interleaver for the channel-coding chain.
//   Sits between encoder and modulator on TX, or between demod and decoder on RX.
//   Ping-pong banks let one bank fill while the other drains, so throughput is 1 symbol/clk.
//   Valid/ready handshake on both sides; the mode is latched per block.
// PARAMETERS
//   ROWS  4  matrix rows, >=2
//   COLS  4  matrix columns, >=2
//   DW    1  symbol width in bits; N = ROWS*COLS symbols per block; IW = $clog2(N)
// PORTS
//   clk        in   1   rising-edge clock
//   rst        in   1   asynchronous reset, active-low
//   mode       in   1   0 = interleave, 1 = deinterleave; sampled with the first symbol of each block
//   in_valid   in   1   input symbol valid
//   in_data    in   DW  input symbol
//   in_ready   out  1   block accepts a symbol; handshake when in_valid && in_ready
//   out_valid  out  1   output symbol valid
//   out_data   out  DW  output symbol
//   out_ready  in   1   downstream accepts; handshake when out_valid && out_ready
//   blk_first  out  1   high with out_valid on the first symbol of each output block
//   flush      in   1   present only with INTLV_FLUSH_EN; synchronous clear
// BEHAVIOUR
//   - Storage: bank[2][N] of DW bits. Per bank: full flag and mode bit. wr_bank/wr_idx drive the write side; rd_bank/rd_idx drive the read side.
//   - Write: on each input handshake, bank[wr_bank][wr_idx] <= in_data (row-major, i = r*COLS+c).
//     At wr_idx==0, mode is stored into the bank's mode bit. Mode changes mid-block are ignored.
//     At wr_idx==N-1: wr_idx <= 0, full[wr_bank] <= 1, wr_bank toggles.
//   - in_ready = !full[wr_bank] (combinational). Stalls only when both banks are full.
//   - Read: out_valid = full[rd_bank]. out_data = bank[rd_bank][perm(rd_idx)] (combinational); 0 when !out_valid.
//     Interleave:   perm(k) = (k % ROWS)*COLS + k/ROWS   (column-major read)
//     Deinterleave: perm(k) = (k % COLS)*ROWS + k/COLS   (exact inverse, including non-square)
//     Compute index arithmetic at IW+1 bits. No out-of-range address is allowed for k < N.
//   - On each output handshake, rd_idx increments. At rd_idx==N-1: rd_idx <= 0, full[rd_bank] <= 0, rd_bank toggles.
//   - out_data and out_valid hold stable while out_valid && !out_ready.
//   - Latency: the first output symbol is valid in the cycle after the edge that accepted the block's last input.
//   - Simultaneous events:
//     * The last write of one bank and the last read of the other bank in the same edge: both take effect.
//     * Set and clear of the same bank's full flag cannot coincide.
//     * When the read side frees a bank on edge t, a stalled writer sees in_ready=1 in the cycle after t.
//   - Reset (rst low, any time, including mid-block):
//     * Pointers, banks, full flags and mode bits go to 0.
//     * in_ready=1, out_valid=0, out_data=0, blk_first=0.
//     * Partial blocks are discarded. Memory contents need no reset.
//   - A partial block never produces output; only complete N-symbol blocks drain.
// CONFIGURATION
//   INTLV_FLUSH_EN defined:
//     * Adds the flush port. flush=1 at an edge has the reset effect synchronously and overrides same-cycle handshakes.
//   INTLV_FLUSH_EN undefined:
//     * No flush port; only rst clears state. Behaviour is otherwise identical.
// TESTING
//   1. ROWS=COLS=4, DW=4, mode=0: in 0..15 -> out 0,4,8,12,1,5,9,13,2,6,10,14,3,7,11,15; blk_first on 0.
//   2. ROWS=2, COLS=3, DW=8:
//      mode=0: in 0..5 -> out 0,3,1,4,2,5.
//      mode=1: in 0,3,1,4,2,5 -> out 0..5.
//   3. 4x4, out_ready=1, 3 back-to-back blocks: in_ready never drops; 48 outputs contiguous;
//      first out_valid exactly 1 cycle after the 16th input.
//   4. 4x4, out_ready=0: in_ready falls after 32 accepted inputs. Raise out_ready with random gaps
//      -> both blocks emerge in correct order, data stable during stalls.
//   5. Assert rst low after 7 of 16 inputs: out_valid=0, in_ready=1 immediately.
//      Then a fresh block 0..15 -> correct permutation, no leftover symbols.
//   6. INTLV_FLUSH_EN defined: flush one cycle during a drain at rd_idx=5 -> out_valid=0 next cycle, no residual output.
//      Mode toggled mid-block -> block keeps its first-symbol mode.

Source files
------------

// File: rtl/block_interleaver_if.sv
// Handshake bundle for block_interleaver: input stream with per-block mode,
// output stream with a first-of-block marker.
interface block_interleaver_if #(
  parameter int DW = 1
);
  logic          mode;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic          blk_first;

  modport master (
    output mode, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, blk_first
  );

  modport slave (
    input  mode, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, blk_first
  );
endinterface

// File: rtl/block_interleaver.sv
// ROWS x COLS ping-pong block (de)interleaver, one symbol per clock on each side.
// Defining INTLV_FLUSH_EN adds a synchronous flush input with the same effect as reset.
module block_interleaver #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int DW   = 1
) (
  input  logic clk,
  input  logic rst,
`ifdef INTLV_FLUSH_EN
  input  logic flush,
`endif
  block_interleaver_if.slave bus
);

  localparam int            N    = ROWS * COLS;
  localparam int            IW   = $clog2(N);
  localparam int            AW   = IW + 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  logic [DW-1:0] mem_q [2][N];

  logic [1:0]    full_q, full_d;
  logic [1:0]    mode_q, mode_d;
  logic          wr_bank_q, wr_bank_d;
  logic          rd_bank_q, rd_bank_d;
  logic [IW-1:0] wr_idx_q, wr_idx_d;
  logic [IW-1:0] rd_idx_q, rd_idx_d;

  logic          clr;
  logic          in_hs;
  logic          out_hs;
  logic          rd_valid;
  logic [AW-1:0] rd_k;
  logic [AW-1:0] rd_addr;
  logic          unused_addr_msb;

`ifdef INTLV_FLUSH_EN
  assign clr = flush;
`else
  assign clr = 1'b0;
`endif

  assign rd_valid = full_q[rd_bank_q];
  assign in_hs    = bus.in_valid && !full_q[wr_bank_q];
  assign out_hs   = rd_valid && bus.out_ready;

  // Bank is written row-major; the read order applies the permutation, so both
  // modes share the same write path and only the read address differs.
  always_comb begin
    rd_k = AW'(rd_idx_q);
    if (mode_q[rd_bank_q]) begin
      rd_addr = (rd_k % AW'(COLS)) * AW'(ROWS) + rd_k / AW'(COLS);
    end else begin
      rd_addr = (rd_k % AW'(ROWS)) * AW'(COLS) + rd_k / AW'(ROWS);
    end
  end

  assign unused_addr_msb = rd_addr[AW-1];

  assign bus.in_ready  = !full_q[wr_bank_q];
  assign bus.out_valid = rd_valid;
  assign bus.out_data  = rd_valid ? mem_q[rd_bank_q][rd_addr[IW-1:0]] : '0;
  assign bus.blk_first = rd_valid && (rd_idx_q == '0);

  // NOTE: combinational next-state uses blocking '=' with every variable given a
  // default first, so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    full_d    = full_q;
    mode_d    = mode_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_idx_d  = wr_idx_q;
    rd_idx_d  = rd_idx_q;

    if (in_hs) begin
      if (wr_idx_q == '0) begin
        mode_d[wr_bank_q] = bus.mode;
      end
      if (wr_idx_q == LAST) begin
        wr_idx_d          = '0;
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = !wr_bank_q;
      end else begin
        wr_idx_d = wr_idx_q + 1'b1;
      end
    end

    // A bank being written is never full, so this clear cannot hit the bank set above.
    if (out_hs) begin
      if (rd_idx_q == LAST) begin
        rd_idx_d          = '0;
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = !rd_bank_q;
      end else begin
        rd_idx_d = rd_idx_q + 1'b1;
      end
    end

    if (clr) begin
      full_d    = '0;
      mode_d    = '0;
      wr_bank_d = 1'b0;
      rd_bank_d = 1'b0;
      wr_idx_d  = '0;
      rd_idx_d  = '0;
    end
  end

  // NOTE: state flops use non-blocking '<=' so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full_q    <= '0;
      mode_q    <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_idx_q  <= '0;
      rd_idx_q  <= '0;
    end else begin
      full_q    <= full_d;
      mode_q    <= mode_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_idx_q  <= wr_idx_d;
      rd_idx_q  <= rd_idx_d;
    end
  end

  // NOTE: symbol storage has no reset; full flags gate every read, so stale
  // contents are never observable and the array can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (in_hs && !clr) begin
      mem_q[wr_bank_q][wr_idx_q] <= bus.in_data;
    end
  end

  // Simulation sanity checks on the read side.
  assert property (@(posedge clk) disable iff (!rst)
    rd_valid |-> (rd_addr < AW'(N)));

  assert property (@(posedge clk) disable iff (!rst)
    (rd_valid && !bus.out_ready && !clr) |=> (rd_valid && $stable(bus.out_data)));

endmodule

// File: tb/tb_block_interleaver.sv
// Self-checking bench: 4x4 instance against a transpose-based reference model,
// 2x3 instance against a table of fixed vectors.
module tb_block_interleaver;

  localparam int AR = 4, AC = 4, ADW = 4, AN = AR * AC;
  localparam int BR = 2, BC = 3, BDW = 8, BN = BR * BC;

  typedef logic [7:0] sym_t;

  typedef struct packed {
    logic [BN-1:0]      md;
    logic [BN-1:0][7:0] din;
    logic [BN-1:0][7:0] dout;
  } bvec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

`ifdef INTLV_FLUSH_EN
  logic flush_a = 1'b0;
  logic flush_b = 1'b0;
`endif

  block_interleaver_if #(.DW(ADW)) ifa ();
  block_interleaver_if #(.DW(BDW)) ifb ();

  block_interleaver #(.ROWS(AR), .COLS(AC), .DW(ADW)) dut_a (
    .clk   (clk),
    .rst   (rst),
`ifdef INTLV_FLUSH_EN
    .flush (flush_a),
`endif
    .bus   (ifa)
  );

  block_interleaver #(.ROWS(BR), .COLS(BC), .DW(BDW)) dut_b (
    .clk   (clk),
    .rst   (rst),
`ifdef INTLV_FLUSH_EN
    .flush (flush_b),
`endif
    .bus   (ifb)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a block is an nr x nc matrix filled row by row and read
  // column by column; deinterleave is the same with the matrix dimensions swapped.
  sym_t a_exp[$];
  logic a_exp_first[$];
  sym_t a_got[$];
  sym_t a_src[$];
  logic a_src_mode[$];
  sym_t a_blk[AN];
  int   a_fill = 0;
  logic a_blk_mode = 1'b0;

  int a_first_out, a_done_cyc, a_rdy_drops, a_stall_acc, a_valid_cyc, a_acc;

  function automatic void a_model_push(input sym_t blk[AN], input logic md);
    int nr;
    int nc;
    nr = md ? AC : AR;
    nc = md ? AR : AC;
    for (int c = 0; c < nc; c++) begin
      for (int r = 0; r < nr; r++) begin
        a_exp.push_back(blk[r * nc + c]);
        a_exp_first.push_back((c == 0) && (r == 0));
      end
    end
  endfunction

  // Drives queued symbols into instance A and scores every output cycle.
  task automatic run_a(input int vld_pct, input int rdy_pct, input int hold, input int max_cyc);
    logic stall;
    sym_t stall_data;
    logic done;
    stall = 1'b0;
    stall_data = '0;
    done = 1'b0;
    a_first_out = -1; a_done_cyc = -1; a_rdy_drops = 0;
    a_stall_acc = -1; a_valid_cyc = 0; a_acc = 0;
    for (int cyc = 0; cyc < max_cyc && !done; cyc++) begin
      @(negedge clk);
      check("a_out_valid_vs_model", ifa.out_valid, a_exp.size() != 0);
      if (stall) check("a_stall_hold_data", ifa.out_data, stall_data);
      if (!ifa.out_valid) begin
        check("a_idle_data", ifa.out_data, 0);
        check("a_idle_first", ifa.blk_first, 0);
      end
      if (a_src.size() == 0 && a_exp.size() == 0) begin
        done = 1'b1;
      end else begin
        ifa.out_ready = (cyc >= hold) && ($urandom_range(99) < rdy_pct);
        if (ifa.out_valid) begin
          a_valid_cyc++;
          if (a_first_out < 0) a_first_out = cyc;
          if (ifa.out_ready && a_exp.size() != 0) begin
            check("a_out_data", ifa.out_data, a_exp.pop_front());
            check("a_blk_first", ifa.blk_first, a_exp_first.pop_front());
            a_got.push_back(sym_t'(ifa.out_data));
          end
        end
        stall = ifa.out_valid && !ifa.out_ready;
        stall_data = sym_t'(ifa.out_data);
        if (!ifa.in_ready) begin
          a_rdy_drops++;
          if (a_stall_acc < 0) a_stall_acc = a_acc;
        end
        if (a_src.size() != 0 && $urandom_range(99) < vld_pct) begin
          ifa.in_valid = 1'b1;
          ifa.in_data  = a_src[0][ADW-1:0];
          ifa.mode     = a_src_mode[0];
        end else begin
          ifa.in_valid = 1'b0;
          ifa.in_data  = ADW'($urandom);
          ifa.mode     = 1'($urandom);
        end
        if (ifa.in_valid && ifa.in_ready) begin
          a_acc++;
          void'(a_src.pop_front());
          void'(a_src_mode.pop_front());
          if (a_fill == 0) a_blk_mode = ifa.mode;
          a_blk[a_fill] = sym_t'(ifa.in_data);
          a_fill++;
          if (a_fill == AN) begin
            a_model_push(a_blk, a_blk_mode);
            a_fill = 0;
            if (a_done_cyc < 0) a_done_cyc = cyc;
          end
        end
      end
    end
    ifa.in_valid  = 1'b0;
    ifa.out_ready = 1'b0;
    check("a_run_drained", a_src.size() + a_exp.size(), 0);
  endtask

  int t1_exp[AN] = '{0, 4, 8, 12, 1, 5, 9, 13, 2, 6, 10, 14, 3, 7, 11, 15};
  int b_il[BN]   = '{0, 3, 1, 4, 2, 5};
  bvec_t bv[4];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    ifa.mode = 0; ifa.in_valid = 0; ifa.in_data = '0; ifa.out_ready = 0;
    ifb.mode = 0; ifb.in_valid = 0; ifb.in_data = '0; ifb.out_ready = 0;

    for (int i = 0; i < BN; i++) begin
      bv[0].md[i] = 1'b0; bv[0].din[i] = 8'(i);               bv[0].dout[i] = 8'(b_il[i]);
      bv[1].md[i] = 1'b1; bv[1].din[i] = 8'(b_il[i]);         bv[1].dout[i] = 8'(i);
      bv[2].md[i] = (i == 0); bv[2].din[i] = 8'(b_il[i] + 32); bv[2].dout[i] = 8'(i + 32);
      bv[3].md[i] = (i != 0); bv[3].din[i] = 8'(160 + i);      bv[3].dout[i] = 8'(160 + b_il[i]);
    end

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_a_in_ready", ifa.in_ready, 1);
    check("rst_a_out_valid", ifa.out_valid, 0);
    check("rst_a_out_data", ifa.out_data, 0);
    check("rst_a_blk_first", ifa.blk_first, 0);
    check("rst_b_in_ready", ifb.in_ready, 1);
    check("rst_b_out_valid", ifb.out_valid, 0);
    rst = 1'b1;

    // 2x3 table vectors, including mode changes after the first symbol
    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < BN; i++) begin
        @(negedge clk);
        check("b_in_ready", ifb.in_ready, 1);
        ifb.in_valid = 1'b1;
        ifb.in_data  = bv[v].din[i];
        ifb.mode     = bv[v].md[i];
      end
      @(negedge clk);
      ifb.in_valid  = 1'b0;
      ifb.mode      = 1'b0;
      ifb.out_ready = 1'b1;
      for (int k = 0; k < BN; k++) begin
        if (k > 0) @(negedge clk);
        check("b_out_valid", ifb.out_valid, 1);
        check("b_out_data", ifb.out_data, bv[v].dout[k]);
        check("b_blk_first", ifb.blk_first, k == 0);
      end
      @(negedge clk);
      ifb.out_ready = 1'b0;
      check("b_drained", ifb.out_valid, 0);
    end

    // Three back-to-back 4x4 blocks at full rate
    a_got.delete();
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < AN; i++) begin
        a_src.push_back(sym_t'(i));
        a_src_mode.push_back(1'b0);
      end
    end
    run_a(100, 100, 0, 400);
    check("t3_no_ready_drop", a_rdy_drops, 0);
    check("t3_first_latency", a_first_out, a_done_cyc + 1);
    check("t3_valid_cycles", a_valid_cyc, 3 * AN);
    check("t1_got_count", a_got.size(), 3 * AN);
    for (int k = 0; k < AN && k < a_got.size(); k++) begin
      check("t1_interleave_order", a_got[k], t1_exp[k]);
    end

    // Output blocked: both banks fill, then drain with random gaps
    for (int i = 0; i < 2 * AN; i++) begin
      a_src.push_back(sym_t'($urandom_range(15)));
      a_src_mode.push_back(1'($urandom));
    end
    run_a(100, 50, 40, 2000);
    check("t4_stall_after_32", a_stall_acc, 2 * AN);

    // Reset in the middle of a block
    for (int i = 0; i < 7; i++) begin
      a_src.push_back(sym_t'(15 - i));
      a_src_mode.push_back(1'b1);
    end
    run_a(100, 100, 0, 100);
    check("t5_partial_held", a_fill, 7);
    rst = 1'b0;
    #1;
    check("t5_rst_in_ready", ifa.in_ready, 1);
    check("t5_rst_out_valid", ifa.out_valid, 0);
    check("t5_rst_out_data", ifa.out_data, 0);
    a_fill = 0;
    a_exp.delete();
    a_exp_first.delete();
    @(negedge clk);
    rst = 1'b1;
    a_got.delete();
    for (int i = 0; i < AN; i++) begin
      a_src.push_back(sym_t'(i));
      a_src_mode.push_back(1'b0);
    end
    run_a(100, 100, 0, 200);
    for (int k = 0; k < AN && k < a_got.size(); k++) begin
      check("t5_fresh_order", a_got[k], t1_exp[k]);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t5_no_leftover", ifa.out_valid, 0);
    end

    // Randomized blocks with random per-symbol mode and random handshakes
    for (int i = 0; i < 6 * AN; i++) begin
      a_src.push_back(sym_t'($urandom_range(15)));
      a_src_mode.push_back(1'($urandom));
    end
    run_a(70, 60, 0, 4000);

`ifdef INTLV_FLUSH_EN
    // Flush in the middle of a drain at rd_idx = 5
    for (int i = 0; i < AN; i++) begin
      @(negedge clk);
      check("f_in_ready", ifa.in_ready, 1);
      ifa.in_valid = 1'b1;
      ifa.in_data  = ADW'(i);
      ifa.mode     = 1'b0;
    end
    @(negedge clk);
    ifa.in_valid  = 1'b0;
    ifa.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check("f_pre_data", ifa.out_data, t1_exp[k]);
      @(negedge clk);
    end
    check("f_rd5_data", ifa.out_data, t1_exp[5]);
    flush_a = 1'b1;
    @(negedge clk);
    flush_a = 1'b0;
    check("f_out_valid", ifa.out_valid, 0);
    check("f_in_ready_after", ifa.in_ready, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("f_no_residual", ifa.out_valid, 0);
    end
    ifa.out_ready = 1'b0;
`endif

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
